// File: rtl/termometre_pkg.sv
// Shared definitions for the thermometer bar driver: default sizes, FSM states
// and the acceptance-time clamp.
package termometre_pkg;

  localparam int WIDTH_DEF = 63;
  localparam int BIN_W_DEF = 6;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_e;

  // Limits a requested level to the top segment; the only saturation point.
  function automatic int unsigned clamp_level(input int unsigned lvl,
                                              input int unsigned max_lvl);
    return (lvl > max_lvl) ? max_lvl : lvl;
  endfunction

endpackage

// File: rtl/termometre_driver_if.sv
// Valid/ready channel that carries a target level into the bar driver.
interface termometre_driver_if
  import termometre_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF
);

  logic [BIN_W-1:0] level;
  logic             level_valid;
  logic             level_ready;

  modport master (output level, output level_valid, input  level_ready);
  modport slave  (input  level, input  level_valid, output level_ready);

endinterface

// File: rtl/termometre_decode.sv
// Binary-to-thermometer decode: bit i is set when bin exceeds i, so any input
// at or above WIDTH lights every segment.
module termometre_decode
  import termometre_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int BIN_W = BIN_W_DEF
) (
  input  logic [BIN_W-1:0] bin,
  output logic [WIDTH-1:0] therm
);

  // Per-segment magnitude compare.
  always_comb begin
    therm = '0;
    for (int i = 0; i < WIDTH; i++) begin
      therm[i] = (32'(bin) > 32'(i));
    end
  end

endmodule

// File: rtl/termometre_driver.sv
// Thermometer bar driver: accepts a target level, ramps the displayed level one
// segment per STEP_DIV cycles and sounds a tone while the level is low.
module termometre_driver
  import termometre_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int BIN_W       = BIN_W_DEF,
  parameter int STEP_DIV    = 1000,
  parameter int ALARM_LEVEL = 10,
  parameter int TONE_DIV    = 2500
) (
  input  logic                clk,
  input  logic                rst,
  termometre_driver_if.slave  lvl_if,
  output logic [BIN_W-1:0]    current,
  output logic [WIDTH-1:0]    termometre,
  output logic                busy,
  output logic                speaker
);

  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int TONE_W = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);
  localparam logic [BIN_W-1:0]  ALARM_LVL = BIN_W'(ALARM_LEVEL);

  state_e            state_r,    state_s;
  logic [BIN_W-1:0]  current_r,  current_s;
  logic [BIN_W-1:0]  target_r,   target_s;
  logic [STEP_W-1:0] step_cnt_r, step_cnt_s;
  logic [TONE_W-1:0] tone_cnt_r;
  logic              speaker_r;
  logic [BIN_W-1:0]  clamped_s;
  logic              alarm_s;

  assign clamped_s = BIN_W'(clamp_level(32'(lvl_if.level), WIDTH));
  assign alarm_s   = (current_r < ALARM_LVL);

  // FSM, ramp step counter and displayed level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      current_r  <= '0;
      target_r   <= '0;
      step_cnt_r <= '0;
    end else begin
      state_r    <= state_s;
      current_r  <= current_s;
      target_r   <= target_s;
      step_cnt_r <= step_cnt_s;
    end
  end

  // Next-state logic: targets are only taken in IDLE, so a ramp is never retargeted.
  always_comb begin
    state_s    = state_r;
    current_s  = current_r;
    target_s   = target_r;
    step_cnt_s = step_cnt_r;
    case (state_r)
      IDLE: begin
        step_cnt_s = '0;
        if (lvl_if.level_valid) begin
          target_s = clamped_s;
          if (clamped_s > current_r) begin
            state_s = RAMP_UP;
          end else if (clamped_s < current_r) begin
            state_s = RAMP_DOWN;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      RAMP_UP: begin
        if (step_cnt_r == STEP_LAST) begin
          step_cnt_s = '0;
          current_s  = current_r + BIN_W'(1);
          if ((current_r + BIN_W'(1)) == target_r) begin
            state_s = IDLE;
          end else begin
            state_s = RAMP_UP;
          end
        end else begin
          step_cnt_s = step_cnt_r + STEP_W'(1);
        end
      end
      RAMP_DOWN: begin
        if (step_cnt_r == STEP_LAST) begin
          step_cnt_s = '0;
          current_s  = current_r - BIN_W'(1);
          if ((current_r - BIN_W'(1)) == target_r) begin
            state_s = IDLE;
          end else begin
            state_s = RAMP_DOWN;
          end
        end else begin
          step_cnt_s = step_cnt_r + STEP_W'(1);
        end
      end
      default: begin
        state_s    = IDLE;
        step_cnt_s = '0;
      end
    endcase
  end

  // Tone generator: free-runs while alarmed, restarts from zero on each new alarm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tone_cnt_r <= '0;
      speaker_r  <= 1'b0;
    end else if (alarm_s) begin
      if (tone_cnt_r == TONE_LAST) begin
        tone_cnt_r <= '0;
        speaker_r  <= ~speaker_r;
      end else begin
        tone_cnt_r <= tone_cnt_r + TONE_W'(1);
      end
    end else begin
      tone_cnt_r <= '0;
      speaker_r  <= 1'b0;
    end
  end

  assign lvl_if.level_ready = (state_r == IDLE);
  assign busy               = (state_r != IDLE);
  assign current            = current_r;
  assign speaker            = speaker_r;

  termometre_decode #(
    .WIDTH (WIDTH),
    .BIN_W (BIN_W)
  ) u_decode (
    .bin   (current_r),
    .therm (termometre)
  );

endmodule

// File: tb/tb_termometre_driver.sv
// Directed bench for termometre_driver: reset, ramps, tone, ignore/no-op,
// extremes, clamp (7-bit instance) and reset during a ramp.
module tb_termometre_driver;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  termometre_driver_if #(.BIN_W(6)) bus ();
  termometre_driver_if #(.BIN_W(7)) bus7 ();

  logic [5:0]  cur;
  logic [62:0] term;
  logic        busy, spk;
  logic [6:0]  cur7;
  logic [62:0] term7;
  logic        busy7, spk7;

  termometre_driver #(
    .WIDTH(63), .BIN_W(6), .STEP_DIV(4), .ALARM_LEVEL(10), .TONE_DIV(3)
  ) dut (
    .clk(clk), .rst(rst), .lvl_if(bus), .current(cur),
    .termometre(term), .busy(busy), .speaker(spk)
  );

  termometre_driver #(
    .WIDTH(63), .BIN_W(7), .STEP_DIV(4), .ALARM_LEVEL(10), .TONE_DIV(3)
  ) dut7 (
    .clk(clk), .rst(rst), .lvl_if(bus7), .current(cur7),
    .termometre(term7), .busy(busy7), .speaker(spk7)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [62:0] all_ones = '1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.level = 6'd0;  bus.level_valid = 1'b0;
    bus7.level = 7'd0; bus7.level_valid = 1'b0;

    // Reset release and tone cadence at current = 0
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      check("tone_after_reset", 64'(spk), 64'((k / 3) % 2));
    end
    #2 rst = 1'b1;
    #1;
    check("rst_current", 64'(cur), 64'd0);
    check("rst_term", 64'(term), 64'd0);
    check("rst_speaker", 64'(spk), 64'd0);
    check("rst_ready", 64'(bus.level_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Ramp up 0 -> 12
    bus.level = 6'd12; bus.level_valid = 1'b1;
    @(posedge clk); #1 bus.level_valid = 1'b0;
    check("up_busy_e0", 64'(busy), 64'd1);
    check("up_ready_e0", 64'(bus.level_ready), 64'd0);
    for (int k = 1; k <= 48; k++) begin
      @(posedge clk); #1;
      check("up_current", 64'(cur), 64'(k / 4));
      if (k == 20) check("up_term_5", 64'(term), 64'h1F);
      if (k >= 41) check("up_speaker_off", 64'(spk), 64'd0);
      if (k == 47) check("up_busy_before_end", 64'(busy), 64'd1);
    end
    check("up_term_12", 64'(term), 64'hFFF);
    check("up_busy_end", 64'(busy), 64'd0);
    check("up_ready_end", 64'(bus.level_ready), 64'd1);

    // Ramp down 12 -> 5, tone restarts once current = 9
    bus.level = 6'd5; bus.level_valid = 1'b1;
    @(posedge clk); #1 bus.level_valid = 1'b0;
    for (int k = 0; k <= 28; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      check("down_current", 64'(cur), 64'(12 - k / 4));
      check("down_speaker", 64'(spk), (k < 12) ? 64'd0 : 64'(((k - 12) / 3) % 2));
    end
    check("down_busy_end", 64'(busy), 64'd0);

    // Ramp 5 -> 20 with a level_valid pulse of 40 mid-ramp
    bus.level = 6'd20; bus.level_valid = 1'b1;
    @(posedge clk); #1 bus.level_valid = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      check("ign_current", 64'(5 + k / 4), 64'(cur));
      if (k == 5) begin
        bus.level = 6'd40; bus.level_valid = 1'b1;
      end
      if (k == 6) begin
        check("ign_ready_low", 64'(bus.level_ready), 64'd0);
        bus.level_valid = 1'b0;
      end
    end
    check("ign_busy_end", 64'(busy), 64'd0);
    check("ign_term_20", 64'(term), 64'hFFFFF);

    // No-op: target equals current
    bus.level = 6'd20; bus.level_valid = 1'b1;
    @(posedge clk); #1 bus.level_valid = 1'b0;
    check("noop_busy", 64'(busy), 64'd0);
    check("noop_ready", 64'(bus.level_ready), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    check("noop_busy_later", 64'(busy), 64'd0);
    check("noop_current", 64'(cur), 64'd20);

    // Extremes: 20 -> 0, then 0 -> 63
    bus.level = 6'd0; bus.level_valid = 1'b1;
    @(posedge clk); #1 bus.level_valid = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    check("ext_zero_current", 64'(cur), 64'd0);
    check("ext_zero_term", 64'(term), 64'd0);
    bus.level = 6'd63; bus.level_valid = 1'b1;
    @(posedge clk); #1 bus.level_valid = 1'b0;
    repeat (251) @(posedge clk);
    #1;
    check("ext_62_current", 64'(cur), 64'd62);
    check("ext_62_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check("ext_63_current", 64'(cur), 64'd63);
    check("ext_63_term", 64'(term), 64'(all_ones));
    check("ext_63_busy", 64'(busy), 64'd0);
    repeat (8) @(posedge clk);
    #1;
    check("ext_no_wrap", 64'(cur), 64'd63);

    // Clamp on the 7-bit instance (100 -> 63) while the 6-bit one returns to 0
    bus7.level = 7'd100; bus7.level_valid = 1'b1;
    bus.level = 6'd0;    bus.level_valid = 1'b1;
    @(posedge clk); #1 bus7.level_valid = 1'b0; bus.level_valid = 1'b0;
    check("clamp_busy_e0", 64'(busy7), 64'd1);
    repeat (251) @(posedge clk);
    #1;
    check("clamp_62", 64'(cur7), 64'd62);
    check("clamp_busy_62", 64'(busy7), 64'd1);
    @(posedge clk); #1;
    check("clamp_63", 64'(cur7), 64'd63);
    check("clamp_busy_end", 64'(busy7), 64'd0);
    check("clamp_term", 64'(term7), 64'(all_ones));
    check("clamp_speaker", 64'(spk7), 64'd0);
    check("back_to_zero_current", 64'(cur), 64'd0);
    check("back_to_zero_term", 64'(term), 64'd0);

    // Reset mid-ramp 0 -> 40 at current = 20
    bus.level = 6'd40; bus.level_valid = 1'b1;
    @(posedge clk); #1 bus.level_valid = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    check("mid_current_20", 64'(cur), 64'd20);
    check("mid_busy", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_current", 64'(cur), 64'd0);
    check("mid_rst_term", 64'(term), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_ready", 64'(bus.level_ready), 64'd1);
    check("mid_rst_speaker", 64'(spk), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("mid_after_current", 64'(cur), 64'd0);
    check("mid_after_busy", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
